// File: rtl/rr_mult_scheduler.sv
// rr_mult_scheduler
//   Round-robin scheduler that shares one repeated-addition multiplier datapath
//   (A/B/P registers plus a B==0 comparator) among NREQ requesters. A granted job
//   loads A, then loads B while clearing P, then adds A into P and decrements B
//   until B==0. The product is returned with a one-cycle response pulse.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req               per-requester job request, held until its response
//   a_in, b_in        packed operands, requester i at [i*WIDTH +: WIDTH]
//   gnt               one-hot grant, held from LOAD_A through RESP
//   busy              high whenever the scheduler is not idle
//   rsp_valid         one-cycle result pulse; rsp_id / rsp_product valid with it
//   dp_data           datapath load bus
//   ldA ldB ldP clrP decB   datapath strobes
//   eqz, dp_product   datapath status: B==0 and the P register

module rr_mult_scheduler #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     a_in,
    input  logic [NREQ*WIDTH-1:0]     b_in,
    output logic [NREQ-1:0]           gnt,
    output logic                      busy,
    output logic                      rsp_valid,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [WIDTH-1:0]          rsp_product,
    output logic [WIDTH-1:0]          dp_data,
    output logic                      ldA,
    output logic                      ldB,
    output logic                      ldP,
    output logic                      clrP,
    output logic                      decB,
    input  logic                      eqz,
    input  logic [WIDTH-1:0]          dp_product
);

    localparam int unsigned IdxW = $clog2(NREQ);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoadA = 3'd1,
        StLoadB = 3'd2,
        StMul   = 3'd3,
        StResp  = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [IdxW-1:0]   ptr_q, ptr_d;
    logic              pick_found;
    logic [IdxW-1:0]   pick_idx;

    // Round-robin search: first requester at or above the pointer, wrapping.
    always_comb begin
        int unsigned     cand;
        logic [IdxW-1:0] cand_idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand     = (32'(ptr_q) + k) % NREQ;
            cand_idx = IdxW'(cand);
            if (!pick_found && req[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    idx_d   = pick_idx;
                    state_d = StLoadA;
                end
            end
            StLoadA: state_d = StLoadB;
            StLoadB: state_d = StMul;
            StMul: begin
                if (eqz) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                // Next search starts just past the requester we served.
                ptr_d   = (idx_q == IdxW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        gnt         = '0;
        busy        = 1'b0;
        rsp_valid   = 1'b0;
        rsp_id      = '0;
        rsp_product = '0;
        dp_data     = '0;
        ldA         = 1'b0;
        ldB         = 1'b0;
        ldP         = 1'b0;
        clrP        = 1'b0;
        decB        = 1'b0;
        if (state_q != StIdle) begin
            gnt[idx_q] = 1'b1;
            busy       = 1'b1;
        end
        unique case (state_q)
            StLoadA: begin
                ldA     = 1'b1;
                dp_data = a_in[32'(idx_q) * WIDTH +: WIDTH];
            end
            StLoadB: begin
                ldB     = 1'b1;
                clrP    = 1'b1;
                dp_data = b_in[32'(idx_q) * WIDTH +: WIDTH];
            end
            StMul: begin
                // One add per remaining count; the eqz cycle itself does nothing.
                ldP  = ~eqz;
                decB = ~eqz;
            end
            StResp: begin
                rsp_valid   = 1'b1;
                rsp_id      = idx_q;
                rsp_product = dp_product;
            end
            default: ;
        endcase
    end

endmodule
